// File: rtl/clkdiv_pkg.sv
// Shared constants and types for the multi-channel clock-enable divider.
package clkdiv_pkg;

    // Default width of the free-running counter and of each divide ratio.
    localparam int unsigned CW_DEF = 32;

    // A divide ratio of zero parks a channel: no ticks, phase frozen.
    localparam int unsigned DIV_DISABLED = 0;

    // Minimum width of a channel index able to address nch channels.
    function automatic int unsigned ch_idx_w(input int unsigned nch);
        return (nch <= 32'd1) ? 32'd1 : $clog2(nch);
    endfunction

    // Per-channel state layout at the default counter width.
    typedef struct packed {
        logic [CW_DEF-1:0] cnt;
        logic [CW_DEF-1:0] div;
        logic [CW_DEF-1:0] shadow;
        logic              pending;
        logic              phase;
    } chan_state_t;

endpackage

// File: rtl/clkdiv_chan.sv
// One programmable divider channel: counter, shadowed retune, tick and phase.
module clkdiv_chan
    import clkdiv_pkg::*;
#(
    parameter int unsigned    CW      = CW_DEF,
    parameter logic [CW-1:0]  RST_DIV = {CW{1'b0}}
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sync_clr_i,
    input  logic          wr_en_i,
    input  logic [CW-1:0] wr_div_i,
    output logic          tick_o,
    output logic          phase_o,
    output logic          pending_o
);

    // Same layout as chan_state_t, sized to this instance's counter width.
    typedef struct packed {
        logic [CW-1:0] cnt;
        logic [CW-1:0] div;
        logic [CW-1:0] shadow;
        logic          pending;
        logic          phase;
    } chan_st_t;

    localparam logic [CW-1:0] ZERO_C = {CW{1'b0}};
    localparam logic [CW-1:0] ONE_C  = CW'(1'b1);
    localparam logic [CW-1:0] DIS_C  = CW'(DIV_DISABLED);

    chan_st_t st_q;
    chan_st_t st_d;
    logic     tick_q;
    logic     tick_d;
    logic     running_s;
    logic     tc_s;

    // Terminal count only exists for an enabled channel, so div-1 never underflows.
    always_comb begin
        running_s = (st_q.div != DIS_C);
        if (running_s) begin
            tc_s = (st_q.cnt == (st_q.div - ONE_C));
        end else begin
            tc_s = 1'b0;
        end
    end

    // Next-state: sync clear wins, then counting, then a config write on top.
    always_comb begin
        st_d   = st_q;
        tick_d = 1'b0;
        if (sync_clr_i) begin
            st_d.cnt   = ZERO_C;
            st_d.phase = 1'b0;
            if (st_q.pending) begin
                st_d.div     = st_q.shadow;
                st_d.pending = 1'b0;
            end else begin
                st_d.div = st_q.div;
            end
        end else begin
            if (!running_s) begin
                st_d.cnt = ZERO_C;
            end else if (tc_s) begin
                st_d.cnt   = ZERO_C;
                st_d.phase = ~st_q.phase;
                tick_d     = 1'b1;
                if (st_q.pending) begin
                    // Retune lands exactly on a period boundary.
                    st_d.div     = st_q.shadow;
                    st_d.pending = 1'b0;
                end else begin
                    st_d.div = st_q.div;
                end
            end else begin
                st_d.cnt = st_q.cnt + ONE_C;
            end

            if (wr_en_i) begin
                if (!running_s || (wr_div_i == DIS_C)) begin
                    // Idle channel or disable request: no period to protect.
                    st_d.div     = wr_div_i;
                    st_d.cnt     = ZERO_C;
                    st_d.pending = 1'b0;
                    if (wr_div_i == DIS_C) begin
                        st_d.phase = 1'b0;
                        tick_d     = 1'b0;
                    end else begin
                        st_d.phase = st_q.phase;
                    end
                end else begin
                    // Running channel: park the ratio until the next terminal count.
                    st_d.shadow  = wr_div_i;
                    st_d.pending = 1'b1;
                end
            end else begin
                st_d.shadow = st_q.shadow;
            end
        end
    end

    // Channel state and tick registers; async reset drops any parked shadow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q.cnt     <= ZERO_C;
            st_q.div     <= RST_DIV;
            st_q.shadow  <= ZERO_C;
            st_q.pending <= 1'b0;
            st_q.phase   <= 1'b0;
            tick_q       <= 1'b0;
        end else begin
            st_q   <= st_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o    = tick_q;
    assign phase_o   = st_q.phase;
    assign pending_o = st_q.pending;

endmodule

// File: rtl/clkdiv_multi.sv
// Free-running counter plus NCH programmable clock-enable divider channels.
module clkdiv_multi
    import clkdiv_pkg::*;
#(
    parameter int unsigned   NCH     = 4,
    parameter int unsigned   CW      = CW_DEF,
    parameter int unsigned   CHW     = 2,
    parameter logic [CW-1:0] RST_DIV = {CW{1'b0}}
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           sync_clr_i,
    input  logic           cfg_valid_i,
    output logic           cfg_ready_o,
    input  logic [CHW-1:0] cfg_ch_i,
    input  logic [CW-1:0]  cfg_div_i,
    output logic [CW-1:0]  free_cnt_o,
    output logic [NCH-1:0] tick_o,
    output logic [NCH-1:0] phase_o
);

    // Every encodable channel index gets a pending bit; unused ones read 0.
    localparam int unsigned NSEL = 1 << CHW;

    logic [CW-1:0]   free_cnt_q;
    logic [CW-1:0]   free_cnt_d;
    logic [NCH-1:0]  pend_s;
    logic [NSEL-1:0] pend_pad_s;
    logic [NCH-1:0]  wr_en_s;
    logic            cfg_ready_s;
    logic            xfer_s;

    // Free counter wraps naturally at 2**CW; only sync clear pulls it back.
    always_comb begin
        if (sync_clr_i) begin
            free_cnt_d = {CW{1'b0}};
        end else begin
            free_cnt_d = free_cnt_q + CW'(1'b1);
        end
    end

    // Free-running counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            free_cnt_q <= {CW{1'b0}};
        end else begin
            free_cnt_q <= free_cnt_d;
        end
    end

    // Ready mux: blocked by a parked retune on the target, or by sync clear.
    always_comb begin
        pend_pad_s  = NSEL'(pend_s);
        cfg_ready_s = ~sync_clr_i & ~pend_pad_s[cfg_ch_i];
        xfer_s      = cfg_valid_i & cfg_ready_s;
    end

    genvar c;
    generate
        for (c = 0; c < NCH; c++) begin : g_chan
            assign wr_en_s[c] = xfer_s & (cfg_ch_i == CHW'(c));

            clkdiv_chan #(
                .CW      (CW),
                .RST_DIV (RST_DIV)
            ) u_chan (
                .clk        (clk),
                .rst        (rst),
                .sync_clr_i (sync_clr_i),
                .wr_en_i    (wr_en_s[c]),
                .wr_div_i   (cfg_div_i),
                .tick_o     (tick_o[c]),
                .phase_o    (phase_o[c]),
                .pending_o  (pend_s[c])
            );
        end
    endgenerate

    assign cfg_ready_o = cfg_ready_s;
    assign free_cnt_o  = free_cnt_q;

endmodule

// File: doc/clkdiv_multi.md
Name: clkdiv_multi

Overview:
- Parametrised successor to the free-running clock divider.
- Keeps a free-running CW-bit count (free_cnt) for legacy bit-tap users.
- Adds NCH independent programmable divider channels. Each channel produces a one-cycle clock-enable tick and a 50%-style phase toggle.
- Used by game logic (bird physics, pipe scroll, VGA/animation timing) as clock enables, never as clocks. Divide ratios are reconfigured at runtime through a valid/ready write port.

Parameters:
- NCH, 4, number of divider channels (1..16)
- CW, 32, width of free_cnt and of each channel divide ratio/counter
- CHW, 2, width of cfg_ch; must satisfy 2**CHW >= NCH
- RST_DIV, 0, divide ratio loaded into every channel at reset (0 = channel disabled)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- sync_clr  in  1  synchronous clear of all counters and phases
- cfg_valid  in  1  config write request
- cfg_ready  out  1  config write accepted when high with cfg_valid
- cfg_ch  in  CHW  target channel index
- cfg_div  in  CW  new divide ratio N (0 = disable)
- free_cnt  out  CW  free-running counter, +1 every cycle, wraps 2**CW-1 -> 0
- tick  out  NCH  per-channel one-cycle enable pulse, registered
- phase  out  NCH  per-channel level, toggles on each tick of that channel

Behaviour:
- Reset (rst=1, async):
  - free_cnt=0, all channel counters=0, div=RST_DIV, tick=0, phase=0.
  - pending flags cleared; cfg_ready=1 after reset.
- free_cnt: increments by 1 every cycle not in sync_clr; modulo 2**CW wrap, no saturation.
- Channel c with div D>=1:
  - Counter cnt counts 0..D-1, then wraps to 0.
  - tick[c]=1 in the cycle after cnt==D-1 is registered, i.e. a tick every D cycles.
  - D=1: tick[c] held high continuously; phase toggles every cycle.
  - First tick after reset/clear arrives exactly D cycles after the release edge.
- Channel with D=0: cnt held 0, tick=0, phase held at current value.
- phase[c] toggles on every tick[c] assertion, giving period 2D.
- Config handshake:
  - cfg_ready = !pending[cfg_ch] (combinational on cfg_ch). A transfer occurs when cfg_valid & cfg_ready.
  - Target channel currently disabled (D=0), or cfg_div=0: new value applied immediately next cycle; cnt reset to 0; phase reset to 0 when cfg_div=0.
  - Target channel running with cfg_div!=0: value stored in shadow[c], pending[c]=1. At the channel's next terminal count (cnt==D-1), div<=shadow, cnt<=0 and pending clears. No shortened or stretched period is ever produced (glitch-free retune).
  - Write accepted in the same cycle as a terminal count on that channel: stored as pending and applied at the following terminal count.
  - Writes to cfg_ch>=NCH are accepted and ignored.
- sync_clr=1:
  - free_cnt, all cnt and phase go to 0; tick=0 next cycle.
  - pending shadows applied immediately and pending cleared.
  - Takes priority over a simultaneous config transfer, which is dropped. cfg_ready is forced 0 during sync_clr so no write is lost silently.
- rst mid-operation: everything returns to reset values asynchronously. Shadows are discarded.
- Arithmetic: cnt compare uses D-1 computed in CW bits; D=0 is never compared (disabled branch).

Decomposition:
- Package clkdiv_pkg holds:
  - CW default and the channel-index width function (clog2)
  - the DIV_DISABLED=0 constant
  - the channel state typedef {cnt, div, shadow, pending, phase}
- Natural sub-module: clkdiv_chan (one channel: counter, shadow/pending, tick, phase), generated NCH times.
- The top handles free_cnt, the config decode and cfg_ready mux.

Test Plan:
- Reset release, RST_DIV=0, run 20 cycles:
  - Required: free_cnt=20, all tick=0, phase=0.
  - Assert rst at cycle 7 of a run: all outputs 0 immediately.
- Write ch0 div=4 while disabled:
  - Required: tick[0] pulses at cycles 4, 8, 12 after the write takes effect.
  - Required: phase[0] = 1,0,1 after those ticks.
- Retune ch1 from div=5 to div=3 mid-count:
  - Required: pending visible (cfg_ready=0 for ch1) until the current 5-cycle period completes, then ticks every 3 cycles with no short period.
  - A second write to ch1 during pending is held off.
- div=1 on ch2: required tick[2]=1 every cycle, phase[2] toggles every cycle. Then write div=0: tick[2]=0 next cycle, phase[2]=0.
- sync_clr pulse with ch3 pending and a simultaneous cfg_valid:
  - Required: cfg_ready=0 that cycle.
  - Required: counters and free_cnt=0; ch3 runs at the shadow ratio immediately.
- free_cnt wrap with CW=4: required 15 -> 0 and continued counting; channel ticks unaffected.
